// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller: serves CPU readM/writeM requests over a shared tri-state
// data bus against a synchronous single-port SRAM, with a parameterised response latency.
module mem_bus_ctrl #(
  parameter int                   LATENCY    = 2,
  parameter int                   WORD_SIZE  = 16,
  parameter logic [WORD_SIZE-1:0] ADDR_LIMIT = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DRIVE,
    RESP,
    REL
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 op_write_q, op_write_d;
  logic                 oor_q, oor_d;
  logic                 first_q, first_d;
  logic                 drive_q, drive_d;
  logic [WORD_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 input_ready_q, input_ready_d;
  logic                 ack_q, ack_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 addr_oor;

  // A full-range limit can never be exceeded, so skip the always-false compare.
  if (ADDR_LIMIT == {WORD_SIZE{1'b1}}) begin : g_full_range
    assign addr_oor = 1'b0;
  end else begin : g_limited_range
    assign addr_oor = (address > ADDR_LIMIT);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_write_d    = op_write_q;
    oor_d         = oor_q;
    first_d       = 1'b0;
    drive_d       = drive_q;
    rd_data_d     = rd_data_q;
    input_ready_d = 1'b0;
    ack_d         = 1'b0;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    err_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (readM && writeM) begin
          err_d   = 1'b1;
          state_d = REL;
        end else if (readM || writeM) begin
          op_write_d = writeM;
          oor_d      = addr_oor;
          first_d    = 1'b1;
          mem_en_d   = !addr_oor;
          mem_we_d   = writeM && !addr_oor;
          mem_addr_d = address;
          if (writeM) begin
            mem_wdata_d = data;
          end
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          drive_d = !op_write_q;
          state_d = DRIVE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DRIVE: begin
        input_ready_d = !op_write_q;
        ack_d         = op_write_q;
        state_d       = RESP;
      end
      RESP: begin
        drive_d = 1'b0;
        state_d = REL;
      end
      REL: begin
        // Wait for the CPU to drop its request so a held level is not served twice.
        if (!readM && !writeM) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (first_q) begin
      err_d = oor_q;
      if (!op_write_q) begin
        rd_data_d = oor_q ? '0 : mem_rdata;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      op_write_q    <= 1'b0;
      oor_q         <= 1'b0;
      first_q       <= 1'b0;
      drive_q       <= 1'b0;
      rd_data_q     <= '0;
      input_ready_q <= 1'b0;
      ack_q         <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_write_q    <= op_write_d;
      oor_q         <= oor_d;
      first_q       <= first_d;
      drive_q       <= drive_d;
      rd_data_q     <= rd_data_d;
      input_ready_q <= input_ready_d;
      ack_q         <= ack_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign data       = drive_q ? rd_data_q : {WORD_SIZE{1'bz}};
  assign inputReady = input_ready_q;
  assign ackOutput  = ack_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-side bus controller that sits directly downstream of the CPU's memory port.
- Answers the CPU's readM/writeM requests over the shared 16-bit address/data bus (data is inout) and returns inputReady or ackOutput.
- Drives a synchronous single-port SRAM, which has a 1-cycle read.
- Response latency and valid address range are set by parameters, so tests can run the CPU against slow memory.

Parameters:
- LATENCY, 2: cycles from request-sample edge to the response pulse edge; legal range 2..15.
- ADDR_LIMIT, 16'hFFFF: highest valid word address; addresses above it are out of range.
- WORD_SIZE, 16: bus and data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- readM  input  1  CPU read request (level).
- writeM  input  1  CPU write request (level).
- address  input  16  CPU word address.
- data  inout  16  shared data bus. Driven only during the read-response window, high-Z otherwise.
- inputReady  output  1  read-data-valid pulse to the CPU.
- ackOutput  output  1  write-complete pulse to the CPU.
- mem_en  output  1  SRAM enable.
- mem_we  output  1  SRAM write enable.
- mem_addr  output  16  SRAM address.
- mem_wdata  output  16  SRAM write data.
- mem_rdata  input  16  SRAM read data, valid at the edge after mem_en.
- busy  output  1  high in any state other than IDLE.
- err  output  1  1-cycle pulse on protocol or range error.

Behaviour:
- Reset (reset_n low, asynchronous):
  - inputReady, ackOutput, mem_en, mem_we, busy and err are 0.
  - mem_addr and mem_wdata are 0; data is high-Z; state is IDLE; counter is 0.
  - Any in-flight access is abandoned, with no response and no late mem_we.
- States: IDLE, WAIT, DRIVE, RESP, REL. Every output is registered.
- IDLE, sampled at edge T0:
  - readM=1, writeM=0: latch address, op=read.
  - writeM=1, readM=0: latch address and data (mem_wdata), op=write.
  - In both cases go to WAIT with cnt=LATENCY-2.
  - readM=1 and writeM=1: err pulses at T0, no access, move to REL.
  - Both low: stay in IDLE.
- SRAM access:
  - mem_en=1 (and mem_we=1 for a write) for exactly one cycle, edge T0 to edge T0+1, with mem_addr set to the latched address.
  - For a read, mem_rdata is captured into the read register at T0+1.
- Out of range (address > ADDR_LIMIT):
  - mem_en and mem_we stay 0.
  - err pulses at T0+1; the read register loads 16'h0000.
  - The handshake still completes on normal timing, so the CPU never hangs.
- WAIT: cnt decrements each edge; leave for DRIVE when cnt==0.
  - With LATENCY=2, DRIVE is entered at T0+1.
  - In general, DRIVE is entered at T0+LATENCY-1.
- DRIVE (read only): data bus drives the read register from edge T0+LATENCY-1. Write ops skip bus drive.
- RESP:
  - At edge T0+LATENCY, inputReady=1 (read) or ackOutput=1 (write) for exactly one cycle.
  - For reads, data stays driven through the whole pulse and goes high-Z at T0+LATENCY+1 together with the pulse fall.
  - The data bus is therefore stable at least one cycle before inputReady rises.
- REL:
  - Stay until readM=0 and writeM=0 are both sampled at one edge, then go to IDLE.
  - A request held high across a completed access is never served twice.
  - A new request is accepted at the earliest one edge after release.
- Requests that change while busy are ignored; address and data were latched at T0.
- busy=1 from T0 until return to IDLE.
- A mid-operation reset gives the reset values immediately, asynchronously. After release, the first request is sampled normally.

Test Plan:
- Read, LATENCY=2:
  - Stimulus: SRAM[0x0010]=0xBEEF, readM=1, address=0x0010 at edge T0.
  - Response: mem_en high for T0..T0+1; data=0xBEEF from T0+1; inputReady high only for T0+2..T0+3; bus high-Z at T0+3.
- Write, LATENCY=4:
  - Stimulus: writeM=1, address=0x0020, data=0x1234 at T0.
  - Response: mem_we=1 for one cycle with mem_addr=0x0020 and mem_wdata=0x1234; ackOutput pulses at T0+4; data never driven.
- Held request:
  - Stimulus: readM held high for 10 cycles after inputReady.
  - Response: exactly one access; the second read is served only after readM is low for at least one edge.
- Protocol error:
  - Stimulus: readM=1 and writeM=1 at the same edge.
  - Response: err pulses one cycle; no mem_en; no inputReady or ackOutput; back to IDLE after both drop.
- Range error:
  - Stimulus: ADDR_LIMIT=16'h00FF, read at 0x0100.
  - Response: no mem_en; err at T0+1; inputReady at T0+LATENCY with data=0x0000.
- Reset mid-operation:
  - Stimulus: reset_n low at T0+1 of a LATENCY=4 write.
  - Response: mem_we, ackOutput and busy all 0 immediately; no ack after release; next read completes correctly.
